// File: rtl/sram_slot_arbiter.sv
`default_nettype none
// sram_slot_arbiter: shares one asynchronous SRAM between pixel writes, frame clear and display reads
// using fixed 4-cycle slots (phases 0-1 write, 2-3 read).  Rev 1.0
module sram_slot_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int CLR_WORDS  = 130560
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        slot_phase,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_data_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLR_WORDS - 1);

  logic [ADDR_W+DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]           r_count;
  logic                     r_live;
  logic                     r_clr_last;
  logic [ADDR_W-1:0]        r_clr_cnt;

  logic              w_full, w_empty, w_push, w_pop;
  logic              w_clr_start, w_slot_edge, w_clr_grant, w_fifo_grant;
  logic [ADDR_W-1:0] w_clr_addr;

  // A clear request seen on the slot edge already owns that slot, so the FIFO can never win against it.
  always_comb begin
    w_full       = (r_count == FULL_CNT);
    w_empty      = (r_count == '0);
    w_clr_start  = clr_req & ~clr_busy;
    w_slot_edge  = (slot_phase == 2'd3);
    w_clr_addr   = w_clr_start ? '0 : r_clr_cnt;
    w_clr_grant  = w_slot_edge & ((clr_busy & ~r_clr_last) | w_clr_start);
    w_fifo_grant = w_slot_edge & ~clr_busy & ~w_clr_start & ~w_empty;
    w_push       = wr_valid & wr_ready & ~w_clr_start;
    w_pop        = w_fifo_grant;
  end

  assign wr_ready = r_live & ~w_full & ~clr_busy;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_clr_start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  // The counter parks on the last address; r_clr_last marks the final clear slot in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
      r_clr_cnt  <= '0;
      r_clr_last <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      if (w_clr_start) begin
        clr_busy   <= 1'b1;
        r_clr_cnt  <= '0;
        r_clr_last <= 1'b0;
      end
      if (w_clr_grant) begin
        if (w_clr_addr == CLR_LAST) r_clr_last <= 1'b1;
        else                        r_clr_cnt  <= w_clr_addr + ADDR_W'(1);
      end
      if (w_slot_edge & clr_busy & r_clr_last) begin
        clr_busy   <= 1'b0;
        clr_done   <= 1'b1;
        r_clr_last <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live       <= 1'b0;
      slot_phase   <= 2'd0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      sram_data_oe <= 1'b0;
      sram_we_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
    end else begin
      r_live     <= 1'b1;
      slot_phase <= slot_phase + 2'd1;
      rd_valid   <= 1'b0;
      case (slot_phase)
        2'd3: begin
          if (!sram_oe_n) begin
            rd_data  <= sram_dq_in;
            rd_valid <= 1'b1;
          end
          sram_oe_n <= 1'b1;
          if (w_clr_grant) begin
            sram_addr    <= w_clr_addr;
            sram_wdata   <= '0;
            sram_data_oe <= 1'b1;
            sram_we_n    <= 1'b0;
          end else if (w_fifo_grant) begin
            {sram_addr, sram_wdata} <= r_mem[r_rd_ptr];
            sram_data_oe <= 1'b1;
            sram_we_n    <= 1'b0;
          end else begin
            sram_data_oe <= 1'b0;
            sram_we_n    <= 1'b1;
          end
        end
        // WE rises here while data stays driven for one more cycle of hold.
        2'd0: sram_we_n <= 1'b1;
        2'd1: begin
          sram_data_oe <= 1'b0;
          if (rd_en) begin
            sram_addr <= rd_addr;
            sram_oe_n <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sram_slot_arbiter.md
SRAM_SLOT_ARBITER -- requirements
Module: sram_slot_arbiter

Interface
REQ-001 Parameter ADDR_W, 18, SRAM address width.
REQ-002 Parameter DATA_W, 24, SRAM data width.
REQ-003 Parameter FIFO_DEPTH, 4, pixel write FIFO depth in entries, power of two.
REQ-004 Parameter CLR_WORDS, 130560, number of words zeroed by a clear (480x272).
REQ-005 clk  in  1  system clock; all logic on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 wr_valid  in  1  pixel write request.
REQ-008 wr_ready  out  1  FIFO can accept a write.
REQ-009 wr_addr  in  ADDR_W  pixel write address.
REQ-010 wr_data  in  DATA_W  pixel write data.
REQ-011 clr_req  in  1  single-cycle pulse requesting a full-frame clear.
REQ-012 clr_busy  out  1  clear in progress.
REQ-013 clr_done  out  1  single-cycle pulse when the clear completes.
REQ-014 rd_en  in  1  display read enable (display on).
REQ-015 rd_addr  in  ADDR_W  display read address, held stable through phases 2-3.
REQ-016 rd_data  out  DATA_W  captured read data.
REQ-017 rd_valid  out  1  single-cycle pulse when rd_data updates.
REQ-018 slot_phase  out  2  current slot phase, 0..3, for display timing.
REQ-019 sram_addr  out  ADDR_W  SRAM address.
REQ-020 sram_wdata  out  DATA_W  SRAM write data.
REQ-021 sram_data_oe  out  1  drive enable for the bidirectional data pins.
REQ-022 sram_dq_in  in  DATA_W  SRAM data pins, read side.
REQ-023 sram_we_n  out  1  SRAM write enable, active-low.
REQ-024 sram_oe_n  out  1  SRAM output enable, active-low.

Function
REQ-025 slot_phase shall increment by 1 every clk, wrapping from 3 to 0.
REQ-026 Each 4-cycle slot shall be split as follows.
- Phases 0-1: write window.
- Phases 2-3: read window.
REQ-027 Write grant shall be decided on the edge entering phase 0, with priority clear > FIFO > idle.
REQ-028 During phases 0-1 of a granted write slot, sram_addr and sram_wdata shall hold the granted address and data.
- sram_data_oe = 1.
- sram_we_n = 0 in phase 0 only, so data is held one cycle past the WE rising edge.
REQ-029 In an idle write slot: sram_we_n = 1 and sram_data_oe = 0.
REQ-030 If rd_en = 1 on the edge entering phase 2:
- sram_addr = rd_addr, sram_oe_n = 0, sram_data_oe = 0 for phases 2-3.
- rd_data shall capture sram_dq_in on the edge leaving phase 3.
- rd_valid shall pulse during the following phase 0.
REQ-031 If rd_en = 0: sram_oe_n = 1, rd_data holds its value, rd_valid = 0.
REQ-032 FIFO: synchronous, FIFO_DEPTH entries, holds {wr_addr, wr_data}.
- Push when wr_valid & wr_ready.
- Pop only at a FIFO-granted write slot.
- A push and a pop in the same cycle shall both take effect.
REQ-033 wr_ready = 0 when the FIFO is full or clr_busy = 1; otherwise 1.
REQ-034 Writes shall reach SRAM in acceptance order; no write shall be dropped or duplicated.
REQ-035 clr_req with clr_busy = 0 shall have the following effect on the next edge:
- Flush the FIFO, discarding any same-cycle push.
- Set clr_busy = 1 and clear the clear-address counter to 0.
REQ-036 clr_req while clr_busy = 1 shall be ignored.
REQ-037 During a clear, each write slot shall write 0 to the counter address, then increment the counter.
REQ-038 After the slot writing address CLR_WORDS-1 ends, clr_busy shall go to 0 and clr_done shall pulse for 1 cycle.
- Total clear time is CLR_WORDS slots.
REQ-039 The clear-address counter width shall be ADDR_W and shall never exceed CLR_WORDS-1.
REQ-040 Reads shall continue during a clear, unaffected.
REQ-041 All SRAM control outputs, rd_valid, clr_busy, clr_done and slot_phase shall be registered.
- No output glitches.
- sram_we_n and sram_oe_n shall never both be 0.

Reset
REQ-042 While rst_n = 0, outputs shall be as follows.
- slot_phase = 0, sram_we_n = 1, sram_oe_n = 1, sram_data_oe = 0.
- sram_addr = 0, sram_wdata = 0, rd_data = 0, rd_valid = 0.
- clr_busy = 0, clr_done = 0, wr_ready = 0.
REQ-043 Reset shall empty the FIFO and abort any clear with no clr_done.
- wr_ready shall rise on the first edge after rst_n deasserts.

Verification
REQ-044 Reset release, rd_en = 0, no requests -> slot_phase cycles 0,1,2,3,0.
- sram_we_n and sram_oe_n stay 1.
- wr_ready = 1 after the first edge.
REQ-045 Push addr 0x00010/data 0xABCDEF in phase 1 -> next slot phase 0 shows sram_we_n = 0 with that addr/data.
- FIFO empty afterwards.
REQ-046 Push 5 writes back-to-back with FIFO_DEPTH = 4 -> wr_ready drops when the FIFO is full.
- All 5 writes appear in order, one per slot.
REQ-047 rd_en = 1, rd_addr = 0x00100, sram_dq_in = 0x123456 -> sram_oe_n = 0 in phases 2-3.
- rd_data = 0x123456 with rd_valid pulsing in the next phase 0.
REQ-048 Three writes queued, then clr_req -> FIFO flushed and clr_busy = 1.
- Addresses 0..CLR_WORDS-1 written with 0.
- clr_done pulses once, 4*CLR_WORDS cycles after start.
- A second clr_req mid-clear is ignored.
REQ-049 rst_n asserted mid-clear -> outputs return to reset values immediately, with no clr_done.
